// File: rtl/input_debouncer.sv
// Debounces an asynchronous pin: 2-flop synchronizer, then a 4-state qualifier that needs DEBOUNCE_CYCLES stable samples.
// Latency: out follows a held level change DEBOUNCE_CYCLES+3 edges after in_raw is first sampled. No backpressure; always accepts.
// Define DEBOUNCER_EDGE_PULSE_EN to generate rise/fall pulses; otherwise both are tied low.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_raw,
    output logic out,
    output logic busy,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        CHECK1  = 2'd1,
        STABLE1 = 2'd2,
        CHECK0  = 2'd3
    } state_t;

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_q;
    logic             out_nxt;

    // in_raw is asynchronous; only sync2 may be consumed by the qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE0;
            cnt   <= '0;
            out_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out_q <= out_nxt;
        end
    end

    // cnt only increments below CNT_MAX, so it can never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            STABLE0: begin
                if (sync2) begin
                    state_nxt = CHECK1;
                    cnt_nxt   = '0;
                end
            end
            CHECK1: begin
                if (!sync2) begin
                    state_nxt = STABLE0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE1: begin
                if (!sync2) begin
                    state_nxt = CHECK0;
                    cnt_nxt   = '0;
                end
            end
            CHECK0: begin
                if (sync2) begin
                    state_nxt = STABLE1;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // out is registered from the next state so it lands on the same edge as the state change.
    always_comb begin
        out_nxt = (state_nxt == STABLE1) || (state_nxt == CHECK0);
    end

    assign out  = out_q;
    assign busy = (state == CHECK1) || (state == CHECK0);

`ifdef DEBOUNCER_EDGE_PULSE_EN
    logic out_d;

    // Reset clears out and out_d together, so reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_d <= 1'b0;
        end else begin
            out_d <= out_q;
        end
    end

    assign rise = out_q & ~out_d;
    assign fall = ~out_q & out_d;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
